// File: rtl/uart_apb_master.sv
// APB initiator for the uart_top register port: one command -> one APB transfer -> one response.
// Absorbs slave wait states and aborts a transfer that waits TIMEOUT_CYC consecutive cycles.
module uart_apb_master #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              busy_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              rsp_valid_d, rsp_err_d, rsp_timeout_d, busy_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    assign cmd_ready_o = (state_q == IDLE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        psel_d        = psel_o;
        penable_d     = penable_o;
        pwrite_d      = pwrite_o;
        paddr_d       = paddr_o;
        pwdata_d      = pwdata_o;
        rsp_valid_d   = rsp_valid_o;
        rsp_rdata_d   = rsp_rdata_o;
        rsp_err_d     = rsp_err_o;
        rsp_timeout_d = rsp_timeout_o;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write_i;
                    paddr_d   = cmd_addr_i;
                    pwdata_d  = cmd_wdata_i;
                    wait_d    = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // Completion is checked first so a ready on the timeout cycle still wins.
                if (pready_i) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_o ? '0 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (TO_EN && (wait_q == WAIT_LAST)) begin
                        state_d       = RESP;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wait_q        <= '0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            wait_q        <= wait_d;
            psel_o        <= psel_d;
            penable_o     <= penable_d;
            pwrite_o      <= pwrite_d;
            paddr_o       <= paddr_d;
            pwdata_o      <= pwdata_d;
            rsp_valid_o   <= rsp_valid_d;
            rsp_rdata_o   <= rsp_rdata_d;
            rsp_err_o     <= rsp_err_d;
            rsp_timeout_o <= rsp_timeout_d;
            busy_o        <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed and randomized bench for uart_apb_master: the bench acts as the APB slave and
// predicts every response and its latency from the command and the chosen wait count.
module tb_uart_apb_master;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic              rsp_valid_o, rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o, rsp_timeout_o, busy_o;
    logic              psel_o, penable_o, pwrite_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o, prdata_i;
    logic              pready_i, pslverr_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_apb_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .busy_o       (busy_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i),
        .pslverr_i    (pslverr_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a transfer whose slave withholds ready for TO cycles is aborted in the
    // TO-th ACCESS cycle; otherwise it ends on the ready cycle, waits+1 ACCESS cycles long.
    function automatic void model(input bit wr, input int waits, input logic [31:0] rd,
                                  input bit serr, output logic [31:0] erd, output bit eerr,
                                  output bit eto, output int elat);
        if (waits >= TO) begin
            erd = 32'h0; eerr = 1'b1; eto = 1'b1; elat = 2 + TO;
        end else begin
            erd = wr ? 32'h0 : rd; eerr = serr; eto = 1'b0; elat = 3 + waits;
        end
    endfunction

    // Entered at a negedge with the DUT idle; leaves at the negedge following hand-off.
    task automatic do_txn(input bit wr, input logic [4:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rd, input bit serr,
                          input int hold, input bit keep_valid);
        logic [31:0] erd;
        bit          eerr, eto, got;
        int          elat, cyc, k;
        model(wr, waits, rd, serr, erd, eerr, eto, elat);

        chk("idle_cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wdata;
        pready_i = 1'b0; rsp_ready_i = (hold == 0);

        @(negedge clk); cyc = 1;
        chk("setup_sel_en_busy_rdy", {psel_o, penable_o, busy_o, cmd_ready_o}, 4'b1010);
        chk("setup_bus", {pwrite_o, paddr_o, pwdata_o}, {wr, addr, wdata});
        // Junk commands while busy must be ignored.
        cmd_valid_i = 1'b1; cmd_write_i = 1'($urandom);
        cmd_addr_i = 5'($urandom); cmd_wdata_i = $urandom;

        got = 1'b0; k = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk); cyc++;
            if (rsp_valid_o) begin
                got = 1'b1;
            end else begin
                chk("access_bus", {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o},
                    {2'b11, wr, addr, wdata});
                pready_i  = (k == waits);
                prdata_i  = (k == waits) ? rd : $urandom;
                pslverr_i = (k == waits) ? serr : 1'($urandom);
                k++;
            end
        end
        pready_i = 1'b0;
        chk("rsp_arrived", got, 1);
        if (!got) return;

        chk("rsp_latency", cyc, elat);
        chk("rsp_bus_released", {psel_o, penable_o, busy_o, cmd_ready_o}, 4'b0010);
        chk("rsp_fields", {rsp_rdata_o, rsp_err_o, rsp_timeout_o}, {erd, eerr, eto});

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("rsp_hold", {rsp_valid_o, cmd_ready_o, psel_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o},
                {3'b100, erd, eerr, eto});
            cmd_addr_i = 5'($urandom); cmd_wdata_i = $urandom;
        end
        rsp_ready_i = 1'b1;

        @(negedge clk);
        chk("handoff", {rsp_valid_o, cmd_ready_o, busy_o, psel_o}, 4'b0100);
        rsp_ready_i = 1'b0;
        if (!keep_valid) cmd_valid_i = 1'b0;
    endtask

    initial begin
        bit          seen;
        int          r, w;
        reset_i = 1'b1;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
        rsp_ready_i = 1'b0; prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
        #1;
        chk("reset_outputs", {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o,
                              rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o}, '0);
        chk("reset_cmd_ready", cmd_ready_o, 1);
        @(negedge clk); @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);

        do_txn(1'b1, 5'h00, 32'h0000_00A5, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        do_txn(1'b0, 5'h08, 32'h0, 3, 32'h0000_1234, 1'b0, 2, 1'b0);
        do_txn(1'b1, 5'h1C, 32'h5A5A_0001, 0, 32'h0, 1'b1, 0, 1'b0);
        do_txn(1'b0, 5'h1C, 32'h0, 0, 32'hCAFE_0042, 1'b0, 1, 1'b0);
        do_txn(1'b0, 5'h04, 32'h0, TO + 4, 32'h1111_2222, 1'b0, 0, 1'b0);
        do_txn(1'b0, 5'h04, 32'h0, TO - 1, 32'h3333_4444, 1'b1, 0, 1'b0);
        do_txn(1'b1, 5'h0C, 32'h0000_0001, 0, 32'h0, 1'b0, 5, 1'b1);
        do_txn(1'b1, 5'h10, 32'h0000_0002, 0, 32'h0, 1'b0, 0, 1'b1);
        do_txn(1'b1, 5'h14, 32'h0000_0003, 0, 32'h0, 1'b0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       w = r % 4;
            else if (r == 6) w = TO - 2;
            else if (r == 7) w = TO - 1;
            else if (r == 8) w = TO;
            else             w = $urandom_range(TO + 1, TO + 8);
            do_txn(1'($urandom), 5'($urandom), $urandom, w, $urandom, 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom));
        end
        cmd_valid_i = 1'b0;

        // Reset in the middle of a waited ACCESS phase.
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 5'h08; pready_i = 1'b0;
        @(negedge clk); cmd_valid_i = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("pre_reset_access", {psel_o, penable_o, busy_o}, 3'b111);
        #2 reset_i = 1'b1;
        #1;
        chk("async_reset_release", {psel_o, penable_o, busy_o, rsp_valid_o, cmd_ready_o}, 5'b00001);
        @(negedge clk); reset_i = 1'b0;
        pready_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid_o || psel_o) seen = 1'b1;
        end
        chk("no_rsp_after_reset", seen, 0);
        chk("post_reset_cmd_ready", cmd_ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
